// File: rtl/yoffset_smooth_scroller_pkg.sv
// Shared definitions for the y-offset smooth scroller: widths, glide states and the S1 payload.
package yoffset_smooth_scroller_pkg;

    localparam int unsigned STEP_W      = 4;
    localparam int unsigned PIX_W       = 10;
    localparam int unsigned OFFSET_W    = 9;
    localparam int unsigned SRC_Y_W     = 11;
    localparam int unsigned STEP_PX_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_UP   = 2'd2
    } glide_state_e;

    // Stage-1 result handed to the address multiply stage
    typedef struct packed {
        logic               valid;
        logic [SRC_Y_W-1:0] src_y;
        logic [PIX_W-1:0]   x;
    } s1_t;

    function automatic logic [OFFSET_W-1:0] min_off(input logic [OFFSET_W-1:0] a,
                                                    input logic [OFFSET_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/yoffset_smooth_scroller_addr_pipe.sv
// Two-stage VGA coordinate to image-ROM address pipeline; rows past the image bottom are not wrapped.
module yoffset_smooth_scroller_addr_pipe
    import yoffset_smooth_scroller_pkg::*;
#(
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned IMG_H  = 960,
    parameter int unsigned ADDR_W = 20
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [PIX_W-1:0]    i_pix_x,
    input  logic [PIX_W-1:0]    i_pix_y,
    input  logic                i_pix_active,
    input  logic [OFFSET_W-1:0] i_offset,
    output logic                o_rd_en,
    output logic [ADDR_W-1:0]   o_rd_addr
);

    localparam logic [SRC_Y_W-1:0] IMG_W_C = SRC_Y_W'(IMG_W);
    localparam logic [SRC_Y_W-1:0] IMG_H_C = SRC_Y_W'(IMG_H);

    s1_t               w_s1;
    s1_t               r_s1;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;

    // S1: offset row and bounds check
    always_comb begin
        w_s1.src_y = SRC_Y_W'(i_pix_y) + SRC_Y_W'(i_offset);
        w_s1.x     = i_pix_x;
        w_s1.valid = i_pix_active && (SRC_Y_W'(i_pix_x) < IMG_W_C) && (w_s1.src_y < IMG_H_C);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1      <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_s1    <= w_s1;
            r_rd_en <= r_s1.valid;
            // S2: linear address, forced to zero when the pixel is outside the image
            r_rd_addr <= r_s1.valid ? (ADDR_W'(r_s1.src_y) * ADDR_W'(IMG_W) + ADDR_W'(r_s1.x))
                                    : '0;
        end
    end

    assign o_rd_en   = r_rd_en;
    assign o_rd_addr = r_rd_addr;

endmodule

// File: rtl/yoffset_smooth_scroller.sv
// Glides the pixel scroll offset toward the arrow-key step target, one bounded step per frame,
// and feeds the coordinate-to-ROM-address pipeline with that offset.
module yoffset_smooth_scroller
    import yoffset_smooth_scroller_pkg::*;
#(
    parameter logic [STEP_W-1:0] MAX_STEP = 4'd14,
    parameter int unsigned       STEP_PX  = STEP_PX_DEF,
    parameter int unsigned       SPEED_PX = 4,
    parameter int unsigned       IMG_W    = 640,
    parameter int unsigned       IMG_H    = 960,
    parameter int unsigned       ADDR_W   = 20
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [STEP_W-1:0]   i_y_offset,
    input  logic                i_frame_start,
    input  logic [PIX_W-1:0]    i_pix_x,
    input  logic [PIX_W-1:0]    i_pix_y,
    input  logic                i_pix_active,
    output logic [OFFSET_W-1:0] o_cur_offset_px,
    output logic                o_moving,
    output logic                o_rd_en,
    output logic [ADDR_W-1:0]   o_rd_addr
);

    localparam logic [OFFSET_W-1:0] SPEED_C = OFFSET_W'(SPEED_PX);
    localparam logic [OFFSET_W-1:0] STEP_C  = OFFSET_W'(STEP_PX);

    glide_state_e        r_state;
    glide_state_e        w_state_nxt;
    logic [OFFSET_W-1:0] r_cur;
    logic [OFFSET_W-1:0] w_cur_nxt;
    logic                r_moving;
    logic                w_moving_nxt;
    logic [STEP_W-1:0]   w_step;
    logic [OFFSET_W-1:0] w_tgt;
    logic [OFFSET_W-1:0] w_dn_dist;
    logic [OFFSET_W-1:0] w_up_dist;

    // Target is only meaningful in the frame_start cycle, where it is consumed directly
    assign w_step    = (i_y_offset > MAX_STEP) ? MAX_STEP : i_y_offset;
    assign w_tgt     = OFFSET_W'(w_step) * STEP_C;
    assign w_dn_dist = w_tgt - r_cur;
    assign w_up_dist = r_cur - w_tgt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Direction is re-decided at every frame_start, so a reversal switches DOWN<->UP at once
    always_comb begin
        w_state_nxt = r_state;
        if (i_frame_start) begin
            if (w_tgt > r_cur) begin
                w_state_nxt = (w_dn_dist <= SPEED_C) ? ST_IDLE : ST_DOWN;
            end else if (w_tgt < r_cur) begin
                w_state_nxt = (w_up_dist <= SPEED_C) ? ST_IDLE : ST_UP;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        w_cur_nxt    = r_cur;
        w_moving_nxt = (w_state_nxt != ST_IDLE);
        if (i_frame_start) begin
            if (w_tgt > r_cur) begin
                w_cur_nxt = r_cur + min_off(SPEED_C, w_dn_dist);
            end else if (w_tgt < r_cur) begin
                w_cur_nxt = r_cur - min_off(SPEED_C, w_up_dist);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur    <= '0;
            r_moving <= 1'b0;
        end else begin
            r_cur    <= w_cur_nxt;
            r_moving <= w_moving_nxt;
        end
    end

    assign o_cur_offset_px = r_cur;
    assign o_moving        = r_moving;

    yoffset_smooth_scroller_addr_pipe #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_pipe (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pix_x      (i_pix_x),
        .i_pix_y      (i_pix_y),
        .i_pix_active (i_pix_active),
        .i_offset     (r_cur),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr)
    );

endmodule
